// File: rtl/giant_hash_load_ctrl_if.sv
// Byte-source, shift-register and control/status bundle for the hash table loader.
interface giant_hash_load_ctrl_if #(
  parameter int CNT_W = 11
);
  logic             start;
  logic             abort;
  logic             byte_valid;
  logic [7:0]       byte_in;
  logic             byte_ready;
  logic             shift_enable;
  logic [7:0]       serial_out;
  logic [CNT_W-1:0] byte_count;
  logic             table_valid;
  logic             consume;
  logic             busy;
  logic             timeout_err;

  modport master (
    output start, abort, byte_valid, byte_in, consume,
    input  byte_ready, shift_enable, serial_out, byte_count,
           table_valid, busy, timeout_err
  );

  modport slave (
    input  start, abort, byte_valid, byte_in, consume,
    output byte_ready, shift_enable, serial_out, byte_count,
           table_valid, busy, timeout_err
  );
endinterface

// File: rtl/giant_hash_load_ctrl.sv
// Sequences a NUM_BYTES load of the target-hash shift register from a valid/ready
// byte source; one-cycle registered shift path, inter-byte timeout, abort from anywhere.
module giant_hash_load_ctrl #(
  parameter int NUM_BYTES = 1024,
  parameter int CNT_W     = 11,
  parameter int TIMEOUT   = 4096,
  parameter int TMR_W     = 13
) (
  input logic                    clk,
  input logic                    n_rst,
  giant_hash_load_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FULL,
    S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             shift_en_q;
  logic [7:0]       serial_q;
  logic             byte_ready;
  logic             accept;

  assign byte_ready = (state_q == S_LOAD) && !bus.abort;
  assign accept     = bus.byte_valid && byte_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      timer_q    <= '0;
      shift_en_q <= 1'b0;
      serial_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      shift_en_q <= accept;
      if (accept) begin
        serial_q <= bus.byte_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      count_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            count_d = '0;
            timer_d = '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            count_d = count_q + CNT_W'(1);
            timer_d = '0;
            if (count_q == CNT_LAST) begin
              state_d = S_DRAIN;
            end
          end else if (timer_q == TMR_LAST) begin
            // Timer parks at its last value so it can never wrap.
            state_d = S_ERROR;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_DRAIN: state_d = S_FULL;
        S_FULL: begin
          if (bus.consume) begin
            state_d = S_IDLE;
          end
        end
        S_ERROR: begin
          if (bus.start) begin
            state_d = S_LOAD;
            count_d = '0;
            timer_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.shift_enable = shift_en_q;
  assign bus.serial_out   = serial_q;
  assign bus.byte_count   = count_q;
  assign bus.table_valid  = (state_q == S_FULL);
  assign bus.busy         = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign bus.timeout_err  = (state_q == S_ERROR);

endmodule

// File: tb/tb_giant_hash_load_ctrl.sv
// Bench for giant_hash_load_ctrl: a small instance (4 bytes, timeout 16) and a default one,
// with a shift-path scoreboard per instance.
module tb_giant_hash_load_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  giant_hash_load_ctrl_if #(.CNT_W(3))  ifs ();
  giant_hash_load_ctrl_if #(.CNT_W(11)) ifd ();

  giant_hash_load_ctrl #(.NUM_BYTES(4), .CNT_W(3), .TIMEOUT(16), .TMR_W(5)) dut_s (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifs)
  );

  giant_hash_load_ctrl dut_d (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifd)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: accepted bytes are queued, popped when the matching shift pulse appears.
  logic [7:0]    sb_s[$];
  logic [7:0]    sb_d[$];
  logic          acc_prev_s, acc_prev_d;
  logic [31:0]   sr_s = '0;
  logic [8191:0] sr_d = '0;
  int            shifts_d = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      sb_s.delete();
      acc_prev_s = 1'b0;
    end else begin
      if (ifs.shift_enable || acc_prev_s) chk("s_shift_timing", ifs.shift_enable, acc_prev_s);
      if (ifs.shift_enable) begin
        sr_s = {sr_s[23:0], ifs.serial_out};
        if (sb_s.size() == 0) chk("s_sb_underflow", sb_s.size(), 1);
        else chk("s_serial", ifs.serial_out, sb_s.pop_front());
      end
      acc_prev_s = ifs.byte_valid && ifs.byte_ready;
      if (acc_prev_s) sb_s.push_back(ifs.byte_in);
    end
  end

  always @(negedge clk) begin
    if (!n_rst) begin
      sb_d.delete();
      acc_prev_d = 1'b0;
    end else begin
      if (ifd.shift_enable || acc_prev_d) chk("d_shift_timing", ifd.shift_enable, acc_prev_d);
      if (ifd.shift_enable) begin
        shifts_d++;
        sr_d = {sr_d[8183:0], ifd.serial_out};
        if (sb_d.size() == 0) chk("d_sb_underflow", sb_d.size(), 1);
        else chk("d_serial", ifd.serial_out, sb_d.pop_front());
      end
      acc_prev_d = ifd.byte_valid && ifd.byte_ready;
      if (acc_prev_d) sb_d.push_back(ifd.byte_in);
    end
  end

  // Present a byte and hold it until the handshake edge; returns just after that edge.
  task automatic send_s(input logic [7:0] b);
    int n = 0;
    ifs.byte_valid = 1'b1;
    ifs.byte_in    = b;
    @(negedge clk);
    while (!ifs.byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("s_send_stall", ifs.byte_ready, 1);
    tick();
  endtask

  task automatic send_d(input logic [7:0] b);
    int n = 0;
    ifd.byte_valid = 1'b1;
    ifd.byte_in    = b;
    @(negedge clk);
    while (!ifd.byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("d_send_stall", ifd.byte_ready, 1);
    tick();
  endtask

  task automatic start_s();
    ifs.start = 1'b1;
    tick();
    ifs.start = 1'b0;
  endtask

  task automatic load_s(input logic [31:0] word);
    start_s();
    for (int i = 3; i >= 0; i--) send_s(word[i*8 +: 8]);
    ifs.byte_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] first_b, last_b, b;
    int k;

    {ifs.start, ifs.abort, ifs.byte_valid, ifs.consume} = '0;
    {ifd.start, ifd.abort, ifd.byte_valid, ifd.consume} = '0;
    ifs.byte_in = 8'h00;
    ifd.byte_in = 8'h00;
    repeat (3) tick();

    chk("rst_s_ready",   ifs.byte_ready,   0);
    chk("rst_s_shift",   ifs.shift_enable, 0);
    chk("rst_s_serial",  ifs.serial_out,   8'h00);
    chk("rst_s_count",   ifs.byte_count,   0);
    chk("rst_s_tvalid",  ifs.table_valid,  0);
    chk("rst_s_busy",    ifs.busy,         0);
    chk("rst_s_terr",    ifs.timeout_err,  0);
    n_rst = 1'b1;
    tick();

    // Reset asserted asynchronously in the middle of a load.
    ifd.start = 1'b1;
    tick();
    ifd.start = 1'b0;
    for (int i = 0; i < 37; i++) send_d(8'(i + 8'h40));
    chk("mid_count", ifd.byte_count, 37);
    chk("mid_busy",  ifd.busy,       1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_ready",  ifd.byte_ready,   0);
    chk("arst_shift",  ifd.shift_enable, 0);
    chk("arst_serial", ifd.serial_out,   8'h00);
    chk("arst_count",  ifd.byte_count,   0);
    chk("arst_busy",   ifd.busy,         0);
    chk("arst_tvalid", ifd.table_valid,  0);
    chk("arst_terr",   ifd.timeout_err,  0);
    repeat (2) tick();
    n_rst = 1'b1;
    // byte_valid stays high in IDLE: never ready.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", ifd.byte_ready, 0);
    end
    ifd.byte_valid = 1'b0;
    tick();

    // Back-to-back small load.
    load_s(32'hA1B2C3D4);
    chk("b2b_drain_busy",   ifs.busy,        1);
    chk("b2b_drain_tvalid", ifs.table_valid, 0);
    tick();
    chk("b2b_full_tvalid", ifs.table_valid, 1);
    chk("b2b_full_count",  ifs.byte_count,  4);
    chk("b2b_sr",          sr_s,            32'hA1B2C3D4);

    // FULL: source valid and start are both ignored.
    ifs.byte_valid = 1'b1;
    ifs.byte_in    = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", ifs.byte_ready, 0);
      tick();
    end
    start_s();
    chk("full_start_tvalid", ifs.table_valid, 1);
    chk("full_start_busy",   ifs.busy,        0);
    ifs.consume = 1'b1;
    ifs.start   = 1'b1;
    tick();
    ifs.consume = 1'b0;
    ifs.start   = 1'b0;
    chk("consume_tvalid", ifs.table_valid, 0);
    chk("consume_busy",   ifs.busy,        0);
    chk("consume_ready",  ifs.byte_ready,  0);
    ifs.byte_valid = 1'b0;
    tick();

    // Abort while in DRAIN.
    load_s(32'h11223344);
    chk("abort_drain_busy", ifs.busy, 1);
    ifs.abort = 1'b1;
    tick();
    ifs.abort = 1'b0;
    chk("abort_drain_tvalid", ifs.table_valid, 0);
    chk("abort_drain_count",  ifs.byte_count,  0);
    chk("abort_drain_busy",   ifs.busy,        0);
    tick();
    chk("abort_drain_stay", ifs.table_valid, 0);
    chk("abort_drain_sr",   sr_s,            32'h11223344);

    // Abort while in FULL.
    load_s(32'hCAFEF00D);
    tick();
    chk("abort_full_pre", ifs.table_valid, 1);
    ifs.abort = 1'b1;
    tick();
    ifs.abort = 1'b0;
    chk("abort_full_tvalid", ifs.table_valid, 0);
    chk("abort_full_count",  ifs.byte_count,  0);
    chk("abort_full_busy",   ifs.busy,        0);
    chk("abort_full_sr",     sr_s,            32'hCAFEF00D);
    tick();

    // Timeout: three bytes, then the source goes quiet.
    start_s();
    send_s(8'h01);
    send_s(8'h02);
    send_s(8'h03);
    ifs.byte_valid = 1'b0;
    k = 0;
    while (!ifs.timeout_err && k < 40) begin
      tick();
      k++;
    end
    chk("to_edges", k, 16);
    chk("to_terr",  ifs.timeout_err, 1);
    chk("to_count", ifs.byte_count,  3);
    chk("to_busy",  ifs.busy,        0);
    start_s();
    chk("to_restart_busy",  ifs.busy,        1);
    chk("to_restart_count", ifs.byte_count,  0);
    chk("to_restart_terr",  ifs.timeout_err, 0);
    repeat (17) tick();
    chk("to_again", ifs.timeout_err, 1);
    ifs.abort = 1'b1;
    ifs.start = 1'b1;
    tick();
    ifs.abort = 1'b0;
    ifs.start = 1'b0;
    chk("to_abort_start_busy", ifs.busy,        0);
    chk("to_abort_start_terr", ifs.timeout_err, 0);
    tick();
    chk("to_abort_start_idle", ifs.busy, 0);

    // Full default-size load from a gapped source.
    shifts_d = 0;
    first_b  = 8'h00;
    last_b   = 8'h00;
    ifd.start = 1'b1;
    tick();
    ifd.start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      k = (i % 16 == 0) ? $urandom_range(0, 100) : $urandom_range(0, 3);
      ifd.byte_valid = 1'b0;
      repeat (k) tick();
      b = 8'($urandom);
      if (i == 0) first_b = b;
      last_b = b;
      send_d(b);
    end
    ifd.byte_valid = 1'b0;
    tick();
    chk("gap_count",  ifd.byte_count,  1024);
    chk("gap_tvalid", ifd.table_valid, 1);
    chk("gap_shifts", shifts_d,        1024);
    chk("gap_sr_top", sr_d[8191:8184], first_b);
    chk("gap_sr_bot", sr_d[7:0],       last_b);
    ifd.consume = 1'b1;
    tick();
    ifd.consume = 1'b0;
    chk("gap_consume_tvalid", ifd.table_valid, 0);
    chk("gap_consume_busy",   ifd.busy,        0);
    repeat (3) tick();

    chk("sb_s_empty", sb_s.size(), 0);
    chk("sb_d_empty", sb_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/giant_hash_load_ctrl.md
Name: giant_hash_load_ctrl

Overview:
- Sequences loading of the 8192-bit target-hash shift register (1024 bytes, 8 bits per shift) from an upstream byte source using a valid/ready handshake.
- Counts the accepted bytes and drives the shift register's shift_enable and serial byte from registered outputs.
- Tells the comparator stage when the table is complete, and holds it until released.
- Detects a stalled upstream source with an inter-byte timeout, and supports abort from any state.

Parameters:
- NUM_BYTES, 1024: bytes per full table (8192 / 8).
- CNT_W, 11: width of the byte counter; must hold NUM_BYTES.
- TIMEOUT, 4096: maximum cycles in LOAD without an accepted byte before the block enters ERROR.
- TMR_W, 13: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load (honoured in IDLE and ERROR).
- abort  in  1  forces IDLE from any state.
- byte_valid  in  1  upstream byte available.
- byte_in  in  8  upstream byte.
- byte_ready  out  1  block accepts byte_in this cycle.
- shift_enable  out  1  registered; drives shift_enable of the hash shift register.
- serial_out  out  8  registered; drives serial_in of the hash shift register.
- byte_count  out  CNT_W  number of bytes accepted in the current load.
- table_valid  out  1  shift register holds a complete table.
- consume  in  1  pulse from the comparator; releases a full table.
- busy  out  1  high in LOAD or DRAIN.
- timeout_err  out  1  high in ERROR.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE.
  - byte_ready=0, shift_enable=0, serial_out=8'h00, byte_count=0, table_valid=0, busy=0, timeout_err=0.
  - Timeout counter cleared.
- Accept: accept = byte_valid & byte_ready.
  - byte_ready is combinational: high only when state==LOAD and abort==0.
- Shift path: on each clock edge, shift_enable <= accept and serial_out <= byte_in when accept (otherwise serial_out holds).
  - Latency is one cycle: a byte accepted in cycle N is shifted in at the end of cycle N+1.
  - The first accepted byte ends up in bits [8191:8184]; the last in [7:0].
- State machine:
  - IDLE:
    - start -> LOAD; byte_count <= 0; timer <= 0.
  - LOAD:
    - On accept: byte_count += 1; timer <= 0.
    - On accept with byte_count==NUM_BYTES-1: -> DRAIN.
    - No accept: timer += 1. Timer reaching TIMEOUT-1 with no accept -> ERROR.
    - start is ignored.
  - DRAIN (one cycle; the final shift completes) -> FULL.
  - FULL:
    - table_valid=1. byte_count holds NUM_BYTES.
    - consume -> IDLE (table_valid low the next cycle). start is ignored.
  - ERROR:
    - timeout_err=1. byte_count holds its value.
    - start -> LOAD with byte_count and timer cleared.
- abort: highest priority in every state; the next state is IDLE. byte_count, timer and table_valid clear on that edge. shift_enable for a byte already accepted before the abort cycle still fires.
- Reloading does not clear the shift register; a full NUM_BYTES load overwrites all of its contents.
- Simultaneous events:
  - In ERROR, abort and start together -> IDLE.
  - In FULL, consume and start together -> IDLE; start is not queued.
- The timeout counter saturates and does not wrap.
- byte_count never exceeds NUM_BYTES.

Test Plan:
1. Reset check: reset mid-LOAD at byte_count=37 -> all outputs return to their reset values asynchronously; the block then sits in IDLE with byte_ready=0.
2. Back-to-back load (NUM_BYTES=4): start, then byte_valid held high with bytes 8'hA1, 8'hB2, 8'hC3, 8'hD4.
   - shift_enable is high for four consecutive cycles, each one cycle after its accept, carrying those serial_out values.
   - table_valid rises two cycles after the last accept.
   - The shift register's top 32 bits read 32'hA1B2C3D4.
3. Gapped source (default params): 1024 bytes sent with random valid gaps of 0–100 cycles.
   - byte_count reaches 1024 and table_valid=1.
   - Exactly 1024 shift_enable pulses occur.
   - consume returns the block to IDLE and table_valid=0.
4. Timeout (TIMEOUT=16): start, 3 bytes, then byte_valid held low.
   - The block enters ERROR 16 cycles after the last accept, with timeout_err=1 and byte_count=3.
   - A subsequent start -> LOAD with byte_count=0.
5. Abort in DRAIN and in FULL -> next cycle: IDLE, table_valid=0, byte_count=0, no extra shift pulses. start is ignored while in FULL.
6. Source byte_valid high in IDLE and FULL -> byte_ready=0 and no shift_enable pulse.
